// File: rtl/instr_data_mem_ws.sv
// Unified instruction/data memory with req/ready handshake, WAIT_CYCLES wait states and byte/half/word access.
// Optional macro MISALIGN_CHECK_EN: report misaligned accesses on err instead of forcing alignment.
module instr_data_mem_ws #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic [1:0]    off_q;
  logic [1:0]    size_q;
  logic          we_q, uns_q;
  logic [31:0]   wd_q;
  logic [31:0]   rd_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [1:0]    off_eff;
  logic          err_w;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          wr_en;
  logic [31:0]   word;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   load_val;

  logic unused_a_hi;
  assign unused_a_hi = ^a[31:AW+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (req) begin
        if (WAIT_CYCLES == 0) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wd_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && req) begin
        idx_q  <= a[AW+1:2];
        off_q  <= a[1:0];
        size_q <= size;
        we_q   <= we;
        uns_q  <= ld_unsigned;
        wd_q   <= wd;
      end
      if (state_q == S_RESP) rd_q <= rd;
    end
  end

`ifdef MISALIGN_CHECK_EN
  assign off_eff = off_q;
  assign err_w   = (size_q == 2'b01 && off_q[0]) || (size_q[1] && off_q != 2'b00);
`else
  // Misaligned low bits are dropped so half/word accesses always hit a naturally aligned slot.
  always_comb begin
    off_eff = off_q;
    if (size_q[1])             off_eff = 2'b00;
    else if (size_q == 2'b01)  off_eff = {off_q[1], 1'b0};
  end
  assign err_w = 1'b0;
`endif

  always_comb begin
    be    = 4'b0001 << off_eff;
    wdata = {4{wd_q[7:0]}};
    if (size_q[1]) begin
      be    = 4'b1111;
      wdata = wd_q;
    end else if (size_q == 2'b01) begin
      be    = off_eff[1] ? 4'b1100 : 4'b0011;
      wdata = {2{wd_q[15:0]}};
    end
  end

  assign wr_en = (state_q == S_RESP) && we_q && !err_w && !rst;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx_q][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign word   = mem[idx_q];
  assign lane_b = word[8*off_eff +: 8];
  assign lane_h = off_eff[1] ? word[31:16] : word[15:0];

  always_comb begin
    if (size_q[1])
      load_val = word;
    else if (size_q == 2'b01)
      load_val = {{16{lane_h[15] & ~uns_q}}, lane_h};
    else
      load_val = {{24{lane_b[7] & ~uns_q}}, lane_b};
  end

  // rd is live during RESP and then held from rd_q until the next response.
  assign ready = (state_q == S_RESP);
  assign rd    = ready ? ((we_q || err_w) ? '0 : load_val) : rd_q;
  assign err   = ready & err_w;

endmodule

// File: tb/tb_instr_data_mem_ws.sv
// Bench for instr_data_mem_ws: directed scenarios plus randomized accesses against a byte-level model.
module tb_instr_data_mem_ws;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, ld_unsigned;
  logic [1:0]  size;
  logic [31:0] a, wd, rd;
  logic        ready, err;
  logic        req0, we0, ld_unsigned0;
  logic [1:0]  size0;
  logic [31:0] a0, wd0, rd0;
  logic        ready0, err0;

  int checks = 0;
  int errors = 0;

  logic [7:0] mb [4096];

  always #5 clk = ~clk;

  instr_data_mem_ws #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .ld_unsigned(ld_unsigned),
    .a(a), .wd(wd), .rd(rd), .ready(ready), .err(err)
  );

  instr_data_mem_ws #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .size(size0), .ld_unsigned(ld_unsigned0),
    .a(a0), .wd(wd0), .rd(rd0), .ready(ready0), .err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One handshake: returns data/err sampled with ready, and cycles from req to ready.
  task automatic access(input bit d0, input bit w, input logic [1:0] sz, input bit un,
                        input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rdv, output logic errv, output int lat);
    bit got;
    @(negedge clk);
    if (d0) begin req0 = 1; we0 = w; size0 = sz; ld_unsigned0 = un; a0 = addr; wd0 = data; end
    else    begin req  = 1; we  = w; size  = sz; ld_unsigned  = un; a  = addr; wd  = data; end
    lat = 0; got = 0; rdv = 'x; errv = 'x;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        if (d0) begin req0 = 0; a0 = $urandom; wd0 = $urandom; end
        else    begin req  = 0; a  = $urandom; wd  = $urandom; end
      end
      if (d0 ? ready0 : ready) begin
        got = 1;
        rdv  = d0 ? rd0 : rd;
        errv = d0 ? err0 : err;
      end
    end
    @(negedge clk);
    chk("ready_pulse", {31'b0, d0 ? ready0 : ready}, 32'd0);
    chk("rd_hold", d0 ? rd0 : rd, rdv);
  endtask

  task automatic op(input string tag, input bit d0, input bit w, input logic [1:0] sz, input bit un,
                    input logic [31:0] addr, input logic [31:0] data,
                    input logic [31:0] exp_rd, input bit exp_err);
    logic [31:0] r; logic e; int l;
    access(d0, w, sz, un, addr, data, r, e, l);
    chk({tag, "_lat"}, l, d0 ? 32'd1 : 32'd3);
    chk({tag, "_rd"}, r, exp_rd);
    chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
  endtask

  // Reference: byte-addressed little-endian memory with the alignment rules applied arithmetically.
  task automatic model(input bit w, input logic [1:0] sz, input bit un, input logic [31:0] addr,
                       input logic [31:0] data, output logic [31:0] exp_rd, output bit exp_err);
    int n; int ea; bit mis; logic [31:0] v;
    n   = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    mis = (addr % n) != 0;
`ifdef MISALIGN_CHECK_EN
    exp_err = mis;
    ea = int'(addr % 4096);
`else
    exp_err = 0;
    ea = int'((addr - (addr % n)) % 4096);
`endif
    exp_rd = 0;
    if (!exp_err) begin
      if (w) begin
        for (int k = 0; k < n; k++) mb[(ea + k) % 4096] = data[8*k +: 8];
      end else begin
        v = 0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mb[(ea + k) % 4096];
        if (!un && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!un && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        exp_rd = v;
      end
    end
  endtask

  initial begin
    logic [31:0] r, er; logic e; bit ee; int l, t1, t2, nready;
    logic [1:0] sz; bit w, un; logic [31:0] addr, data;
    rst = 1; req = 0; we = 0; size = 0; ld_unsigned = 0; a = 0; wd = 0;
    req0 = 0; we0 = 0; size0 = 0; ld_unsigned0 = 0; a0 = 0; wd0 = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rd", rd, 32'd0);
    chk("rst_rd0", rd0, 32'd0);
    rst = 0;

    op("st_word", 0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    op("ld_word", 0, 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);

    op("pre20", 0, 1, 2'd2, 0, 32'h20, 32'h11223344, 32'h0, 0);
    op("st_byte", 0, 1, 2'd0, 0, 32'h21, 32'h000000AA, 32'h0, 0);
    op("ld_w20", 0, 0, 2'd2, 0, 32'h20, 32'h0, 32'h1122AA44, 0);
    op("ld_bs", 0, 0, 2'd0, 0, 32'h21, 32'h0, 32'hFFFFFFAA, 0);
    op("ld_bu", 0, 0, 2'd0, 1, 32'h21, 32'h0, 32'h000000AA, 0);

    op("pre30", 0, 1, 2'd2, 0, 32'h30, 32'h76543210, 32'h0, 0);
    op("st_half", 0, 1, 2'd1, 0, 32'h32, 32'h00008001, 32'h0, 0);
    op("ld_hs", 0, 0, 2'd1, 0, 32'h32, 32'h0, 32'hFFFF8001, 0);
    op("ld_hu", 0, 0, 2'd1, 1, 32'h32, 32'h0, 32'h00008001, 0);
    op("ld_w30", 0, 0, 2'd2, 0, 32'h30, 32'h0, 32'h80013210, 0);

    op("pre40", 0, 1, 2'd2, 0, 32'h40, 32'hCAFEF00D, 32'h0, 0);
`ifdef MISALIGN_CHECK_EN
    op("st_mis", 0, 1, 2'd2, 0, 32'h41, 32'h01020304, 32'h0, 1);
    op("ld_w40", 0, 0, 2'd2, 0, 32'h40, 32'h0, 32'hCAFEF00D, 0);
    op("ld_hmis", 0, 0, 2'd1, 0, 32'h43, 32'h0, 32'h0, 1);
`else
    op("st_mis", 0, 1, 2'd2, 0, 32'h41, 32'h01020304, 32'h0, 0);
    op("ld_w40", 0, 0, 2'd2, 0, 32'h40, 32'h0, 32'h01020304, 0);
    op("ld_hmis", 0, 0, 2'd1, 0, 32'h43, 32'h0, 32'h00000102, 0);
`endif

    // Reset in the WAIT cycle of a store must abort it without writing.
    op("pre50", 0, 1, 2'd2, 0, 32'h50, 32'h5555AAAA, 32'h0, 0);
    @(negedge clk);
    req = 1; we = 1; size = 2'd2; a = 32'h50; wd = 32'h12345678;
    @(negedge clk);
    req = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    nready = 0;
    repeat (6) begin
      @(negedge clk);
      if (ready) nready++;
    end
    chk("abort_noready", nready, 32'd0);
    chk("abort_rd", rd, 32'd0);
    op("ld_w50", 0, 0, 2'd2, 0, 32'h50, 32'h0, 32'h5555AAAA, 0);

    // req held high through RESP: next acceptance comes in the IDLE cycle after ready.
    @(negedge clk);
    req = 1; we = 0; size = 2'd2; ld_unsigned = 0; a = 32'h10;
    t1 = 0; t2 = 0; l = 0;
    while (t2 == 0 && l < 30) begin
      @(negedge clk);
      l++;
      if (ready) begin
        if (t1 == 0) t1 = l;
        else begin t2 = l; r = rd; req = 0; end
      end
    end
    req = 0;
    chk("hold_t1", t1, 32'd3);
    chk("hold_t2", t2, 32'd7);
    chk("hold_rd", r, 32'hDEADBEEF);

    // Zero-wait instance: address wrap modulo DEPTH_WORDS*4.
    op("z_st0", 1, 1, 2'd2, 0, 32'h0, 32'h0F0F0F0F, 32'h0, 0);
    op("z_wrap", 1, 0, 2'd2, 0, 32'h1000, 32'h0, 32'h0F0F0F0F, 0);
    op("z_st2008", 1, 1, 2'd2, 0, 32'h2008, 32'hA5A5_1234, 32'h0, 0);
    op("z_ld8", 1, 0, 2'd1, 0, 32'h8, 32'h0, 32'h00001234, 0);

    // Randomized accesses in a pre-initialized window.
    for (int i = 0; i < 16; i++) begin
      data = $urandom;
      model(1, 2'd2, 0, 32'h100 + 4*i, data, er, ee);
      op("rinit", 0, 1, 2'd2, 0, 32'h100 + 4*i, data, er, ee);
    end
    for (int i = 0; i < 40; i++) begin
      sz   = 2'($urandom_range(0, 3));
      w    = 1'($urandom_range(0, 1));
      un   = 1'($urandom_range(0, 1));
      addr = 32'h100 + $urandom_range(0, 63);
      data = $urandom;
      model(w, sz, un, addr, data, er, ee);
      op("rand", 0, w, sz, un, addr, data, er, ee);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
